// File: rtl/naneye_pkg.sv
// naneye_pkg: shared widths, packer state encoding and word-packing helpers for the NanEye receive chain
package naneye_pkg;
  localparam int PIX_W        = 10;
  localparam int PIX_PER_WORD = 3;
  localparam int WORD_W       = 32;
  localparam int SLOT_W       = PIX_W * PIX_PER_WORD;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_FLUSH  = 2'd2
  } state_e;
  // count field in word bits [31:30]: number of valid pixels, 1..3
  localparam logic [1:0] CNT_FULL = 2'd3;
  function automatic logic [SLOT_W-1:0] place_pix(input logic [PIX_W-1:0] pix, input logic [1:0] slot);
    return SLOT_W'(pix) << (PIX_W * slot);
  endfunction
  function automatic logic [WORD_W-1:0] pack_word(input logic [1:0] cnt, input logic [SLOT_W-1:0] px);
    return {cnt, px};
  endfunction
endpackage

// File: rtl/pixel_word_fifo.sv
// pixel_word_fifo: synchronous FIFO with first-word fall-through registered output and full/empty flags
module pixel_word_fifo #(
  parameter int AW = 4,
  parameter int W  = 34
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_i,
  input  logic [W-1:0] din_i,
  input  logic         rd_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int DEPTH = 2 ** AW;
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q, rd_n;
  logic [AW:0]   cnt_q, left;
  logic [W-1:0]  dout_q;
  logic          pop, push;
  assign full_o  = cnt_q == (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign dout_o  = dout_q;
  // a read frees a slot in the same cycle, so a write into a full FIFO that is being read still lands
  always_comb begin
    pop  = ~empty_o & rd_i;
    push = wr_i & (~full_o | pop);
    left = cnt_q - (AW+1)'(pop);
    rd_n = rd_q + AW'(pop);
  end
  // storage array, written only on accepted pushes
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= din_i;
  // pointers, occupancy and the output register that always holds the current head word
  always_ff @(posedge clk)
    if (rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
    end else begin
      rd_q   <= rd_n;
      wr_q   <= wr_q + AW'(push);
      cnt_q  <= left + (AW+1)'(push);
      dout_q <= (left != '0) ? mem_q[rd_n] : push ? din_i : '0;
    end
endmodule

// File: rtl/pixel_word_packer.sv
// pixel_word_packer: packs 10-bit pixels three per 32-bit word with SOF/EOL into an output FIFO; PACKER_STATS_EN adds line/frame statistics
module pixel_word_packer
  import naneye_pkg::*;
#(
  parameter int FIFO_AW = 4,
  parameter int STAT_W  = 16
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic [PIX_W-1:0]  PIX_IN,
  input  logic              PIX_VALID,
  input  logic              H_SYNC,
  input  logic              V_SYNC,
  output logic [WORD_W-1:0] OUT_DATA,
  output logic              OUT_SOF,
  output logic              OUT_EOL,
  output logic              OUT_VALID,
  input  logic              OUT_READY,
  output logic              OVERFLOW,
  output logic [STAT_W-1:0] LINE_PIX,
  output logic [STAT_W-1:0] FRAME_CNT
);
  state_e              st_q, st_d;
  logic [1:0]          slot_q, slot_d, n;
  logic [SLOT_W-1:0]   acc_q, acc_d, acc_ins;
  logic [WORD_W+1:0]   ww_q, ww_d, dout;
  logic                hs_q, vs_q, sof_q, sof_d, wr_q, wr_d, ovf_q;
  logic                rise, fall, in_line, take, full_w, eol_ok, emit, clr;
  logic                fifo_full, fifo_empty, drop;
  // pixel slotting, word completion and SOF arming; a completed word is staged for next-cycle FIFO write
  always_comb begin
    rise    = V_SYNC & ~vs_q;
    fall    = ~H_SYNC & hs_q;
    in_line = st_q != S_IDLE;
    take    = in_line & ~rise & PIX_VALID;
    n       = slot_q + {1'b0, take};
    acc_ins = acc_q | (take ? place_pix(PIX_IN, slot_q) : '0);
    full_w  = n == CNT_FULL;
    eol_ok  = fall & (st_q == S_ACTIVE) & ~rise;
    emit    = in_line & ~rise & (full_w | (eol_ok & (n != 2'd0)));
    clr     = rise | emit | ~in_line;
    st_d    = rise ? S_ACTIVE : ~in_line ? S_IDLE : (emit & ~full_w) ? S_FLUSH : S_ACTIVE;
    slot_d  = clr ? 2'd0 : n;
    acc_d   = clr ? '0 : acc_ins;
    sof_d   = rise | (sof_q & ~emit);
    wr_d    = emit;
    ww_d    = {pack_word(n, acc_ins), sof_q, eol_ok};
  end
  assign drop = wr_q & fifo_full & ~(OUT_VALID & OUT_READY);
  // state, sync history, staging register and sticky overflow
  always_ff @(posedge CLOCK)
    if (RESET) begin
      st_q   <= S_IDLE;
      slot_q <= '0;
      acc_q  <= '0;
      hs_q   <= 1'b0;
      vs_q   <= 1'b0;
      sof_q  <= 1'b0;
      wr_q   <= 1'b0;
      ww_q   <= '0;
      ovf_q  <= 1'b0;
    end else begin
      st_q   <= st_d;
      slot_q <= slot_d;
      acc_q  <= acc_d;
      hs_q   <= H_SYNC;
      vs_q   <= V_SYNC;
      sof_q  <= sof_d;
      wr_q   <= wr_d;
      ww_q   <= ww_d;
      ovf_q  <= ovf_q | drop;
    end
  pixel_word_fifo #(.AW(FIFO_AW), .W(WORD_W + 2)) u_fifo (
    .clk    (CLOCK),
    .rst    (RESET),
    .wr_i   (wr_q),
    .din_i  (ww_q),
    .rd_i   (OUT_READY),
    .dout_o (dout),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );
  assign OUT_VALID                    = ~fifo_empty;
  assign {OUT_DATA, OUT_SOF, OUT_EOL} = dout;
  assign OVERFLOW                     = ovf_q;
`ifdef PACKER_STATS_EN
  logic [STAT_W-1:0] line_q, line_inc, lpix_q, frame_q;
  assign line_inc = (take & ~&line_q) ? line_q + 1'b1 : line_q;
  // saturating per-line pixel count latched at line end, and a wrapping frame-start counter
  always_ff @(posedge CLOCK)
    if (RESET) begin
      line_q  <= '0;
      lpix_q  <= '0;
      frame_q <= '0;
    end else begin
      line_q  <= (rise | eol_ok) ? '0 : line_inc;
      lpix_q  <= eol_ok ? line_inc : lpix_q;
      frame_q <= frame_q + STAT_W'(rise);
    end
  assign LINE_PIX  = lpix_q;
  assign FRAME_CNT = frame_q;
`else
  assign LINE_PIX  = '0;
  assign FRAME_CNT = '0;
`endif
endmodule

// File: tb/tb_pixel_word_packer.sv
// tb_pixel_word_packer: randomized and directed stimulus against a pixel-list reference model with a scoreboard monitor
module tb_pixel_word_packer;
  localparam int DEPTH = 16;
  logic        clk = 1'b0, rst = 1'b1;
  logic [9:0]  PIX_IN = '0;
  logic        PIX_VALID = 1'b0, H_SYNC = 1'b0, V_SYNC = 1'b0, OUT_READY = 1'b0;
  logic [31:0] OUT_DATA;
  logic        OUT_SOF, OUT_EOL, OUT_VALID, OVERFLOW;
  logic [15:0] LINE_PIX, FRAME_CNT;

  always #5 clk = ~clk;

  pixel_word_packer dut (
    .CLOCK(clk), .RESET(rst), .PIX_IN(PIX_IN), .PIX_VALID(PIX_VALID),
    .H_SYNC(H_SYNC), .V_SYNC(V_SYNC), .OUT_DATA(OUT_DATA), .OUT_SOF(OUT_SOF),
    .OUT_EOL(OUT_EOL), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .OVERFLOW(OVERFLOW), .LINE_PIX(LINE_PIX), .FRAME_CNT(FRAME_CNT)
  );

  int n_vec = 0, n_bad = 0, n_pop = 0, rdy_mode = 0;
  logic [33:0] sb[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // reference model: pixels accumulate in a list; a word leaves when three are held or a line ends
  bit          m_act, m_sof, m_hs, m_vs, m_rise, m_fall, exp_ovf;
  logic [9:0]  pend[$];
  int          m_line, exp_line, exp_frame;

  task automatic emit(input bit eol);
    logic [31:0] w;
    w = '0;
    foreach (pend[i]) w[i*10 +: 10] = pend[i];
    w[31:30] = 2'(pend.size());
    if (sb.size() >= DEPTH) exp_ovf = 1'b1;
    else sb.push_back({w, m_sof, eol});
    m_sof = 1'b0;
    pend.delete();
  endtask

  always @(negedge clk) begin
    if (rst) begin
      m_act = 0; m_sof = 0; m_hs = 0; m_vs = 0; exp_ovf = 0;
      pend.delete(); sb.delete();
      m_line = 0; exp_line = 0; exp_frame = 0;
    end else begin
      m_rise = V_SYNC && !m_vs;
      m_fall = !H_SYNC && m_hs;
      if (m_rise) begin
        exp_frame++;
        m_line = 0;
        m_act = 1;
        m_sof = 1;
        pend.delete();
      end else if (m_act) begin
        if (PIX_VALID) begin
          pend.push_back(PIX_IN);
          m_line++;
        end
        if (m_fall) begin
          exp_line = (m_line > 65535) ? 65535 : m_line;
          m_line = 0;
        end
        if (pend.size() == 3 || (m_fall && pend.size() != 0)) emit(m_fall);
      end
      m_hs = H_SYNC;
      m_vs = V_SYNC;
    end
  end

  // monitor: pops the scoreboard on each accepted word and checks outputs hold while stalled
  logic [34:0] held;
  bit          hold_chk;
  always @(negedge clk) begin
    if (rst) hold_chk = 0;
    else begin
      if (hold_chk) check("hold", 64'({OUT_VALID, OUT_DATA, OUT_SOF, OUT_EOL}), 64'(held));
      if (OUT_VALID && OUT_READY) begin
        n_pop++;
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL word: got %0h expected no word", {OUT_DATA, OUT_SOF, OUT_EOL});
        end else check("word", 64'({OUT_DATA, OUT_SOF, OUT_EOL}), 64'(sb.pop_front()));
      end
      hold_chk = OUT_VALID && !OUT_READY;
      held = {OUT_VALID, OUT_DATA, OUT_SOF, OUT_EOL};
    end
  end

  task automatic set_in(input bit pv, input logic [9:0] px, input bit hs, input bit vs);
    PIX_VALID = pv;
    PIX_IN = px;
    H_SYNC = hs;
    V_SYNC = vs;
    OUT_READY = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
  endtask

  task automatic cyc(input bit pv, input logic [9:0] px, input bit hs, input bit vs);
    set_in(pv, px, hs, vs);
    @(posedge clk);
    #1;
  endtask

  task automatic vpulse();
    cyc(0, 10'd0, 0, 1);
    cyc(0, 10'd0, 0, 0);
  endtask

  task automatic line(input int n, input bit gaps);
    cyc(0, 10'd0, 1, 0);
    for (int i = 0; i < n; i++) begin
      if (gaps) repeat ($urandom_range(0, 2)) cyc(0, 10'($urandom), 1, 0);
      cyc(1, 10'($urandom), i != n - 1, 0);
    end
    if (n == 0) cyc(0, 10'd0, 0, 0);
    cyc(gaps ? 1'($urandom_range(0, 1)) : 1'b0, 10'($urandom), 0, 0);
  endtask

  task automatic chk_stats();
`ifdef PACKER_STATS_EN
    check("line_pix", 64'(LINE_PIX), 64'(exp_line[15:0]));
    check("frame_cnt", 64'(FRAME_CNT), 64'(exp_frame[15:0]));
`else
    check("line_pix_off", 64'(LINE_PIX), 64'h0);
    check("frame_cnt_off", 64'(FRAME_CNT), 64'h0);
`endif
  endtask

  initial begin
    int p0;
    cyc(0, 10'd0, 0, 0);
    cyc(0, 10'd0, 0, 0);
    rst = 1'b0;
    check("rst_valid", 64'(OUT_VALID), 64'h0);
    check("rst_data", 64'(OUT_DATA), 64'h0);
    check("rst_sof", 64'(OUT_SOF), 64'h0);
    check("rst_eol", 64'(OUT_EOL), 64'h0);
    check("rst_ovf", 64'(OVERFLOW), 64'h0);
    chk_stats();

    rdy_mode = 1;
    for (int i = 0; i < 8; i++) cyc(1, 10'($urandom), i[0], 0);
    repeat (3) cyc(0, 10'd0, 0, 0);
    check("idle_ignored", 64'(OUT_VALID), 64'h0);

    vpulse();
    cyc(0, 10'd0, 1, 0);
    cyc(1, 10'h001, 1, 0);
    cyc(1, 10'h002, 1, 0);
    set_in(1, 10'h003, 1, 0);
    @(negedge clk); check("lat0", 64'(OUT_VALID), 64'h0);
    @(posedge clk); #1;
    set_in(1, 10'h004, 1, 0);
    @(negedge clk); check("lat1", 64'(OUT_VALID), 64'h0);
    @(posedge clk); #1;
    set_in(1, 10'h005, 1, 0);
    @(negedge clk);
    check("lat2", 64'(OUT_VALID), 64'h1);
    check("w0_data", 64'(OUT_DATA), 64'hC030_0801);
    check("w0_sof_eol", 64'({OUT_SOF, OUT_EOL}), 64'h2);
    @(posedge clk); #1;
    cyc(1, 10'h006, 0, 0);
    cyc(0, 10'd0, 0, 0);
    @(negedge clk);
    check("w1_data", 64'(OUT_DATA), 64'hC060_1404);
    check("w1_sof_eol", 64'({OUT_SOF, OUT_EOL}), 64'h1);
    @(posedge clk); #1;
    chk_stats();

    cyc(0, 10'd0, 1, 0);
    repeat (3) cyc(1, 10'h3FF, 1, 0);
    cyc(1, 10'h3FF, 0, 0);
    cyc(1, 10'h155, 0, 0);
    cyc(0, 10'd0, 1, 0);
    cyc(1, 10'h156, 1, 0);
    cyc(1, 10'h157, 0, 0);
    repeat (4) cyc(0, 10'd0, 0, 0);
    chk_stats();

    vpulse();
    cyc(0, 10'd0, 1, 0);
    cyc(1, 10'h0AA, 1, 0);
    cyc(1, 10'h0BB, 1, 0);
    cyc(0, 10'd0, 1, 1);
    cyc(0, 10'd0, 1, 0);
    cyc(1, 10'h0CC, 1, 0);
    cyc(1, 10'h0DD, 0, 0);
    repeat (4) cyc(0, 10'd0, 0, 0);
    chk_stats();

    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      vpulse();
      for (int l = 0; l < 4; l++) line($urandom_range(0, 11), 1);
      chk_stats();
    end
    rdy_mode = 1;
    repeat (20) cyc(0, 10'd0, 0, 0);
    check("rand_drained", 64'(sb.size()), 64'h0);
    check("rand_no_ovf", 64'(OVERFLOW), 64'h0);

    rdy_mode = 0;
    vpulse();
    cyc(0, 10'd0, 1, 0);
    for (int i = 0; i < 60; i++) cyc(1, 10'($urandom), 1, 0);
    cyc(0, 10'd0, 0, 0);
    repeat (3) cyc(0, 10'd0, 0, 0);
    check("ovf_set", 64'(OVERFLOW), 64'(exp_ovf));
    check("ovf_valid", 64'(OUT_VALID), 64'h1);
    check("ovf_held", 64'(sb.size()), 64'(DEPTH));
    chk_stats();
    p0 = n_pop;
    rdy_mode = 1;
    repeat (30) cyc(0, 10'd0, 0, 0);
    check("ovf_drain_count", 64'(n_pop - p0), 64'(DEPTH));
    check("ovf_drain_empty", 64'(OUT_VALID), 64'h0);

    rdy_mode = 0;
    vpulse();
    cyc(0, 10'd0, 1, 0);
    for (int i = 0; i < 9; i++) cyc(1, 10'($urandom), 1, 0);
    repeat (3) cyc(0, 10'd0, 1, 0);
    check("rst_pre_valid", 64'(OUT_VALID), 64'h1);
    cyc(1, 10'($urandom), 1, 0);
    rst = 1'b1;
    cyc(1, 10'($urandom), 1, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 64'(OUT_VALID), 64'h0);
    check("rst_mid_ovf", 64'(OVERFLOW), 64'h0);
    @(posedge clk); #1;
    rdy_mode = 1;
    for (int i = 0; i < 12; i++) cyc(1, 10'($urandom), i < 10, 0);
    repeat (3) cyc(0, 10'd0, 0, 0);
    check("rst_ignored", 64'(OUT_VALID), 64'h0);
    chk_stats();
    vpulse();
    line(5, 0);
    repeat (4) cyc(0, 10'd0, 0, 0);
    chk_stats();

    cyc(0, 10'd0, 1, 0);
    for (int i = 0; i < 249; i++) cyc(1, 10'($urandom), 1, 0);
    cyc(1, 10'($urandom), 0, 0);
`ifdef PACKER_STATS_EN
    check("line250", 64'(LINE_PIX), 64'd250);
`else
    check("line250_off", 64'(LINE_PIX), 64'h0);
`endif
    chk_stats();
    repeat (20) cyc(0, 10'd0, 0, 0);
    check("final_drained", 64'(sb.size()), 64'h0);
    check("final_ovf", 64'(OVERFLOW), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
